// File: rtl/lfsr_bank.sv
// Bank of NUM_CH XNOR-form LFSRs sharing one programmable tap mask and one control FSM.
// Beats leave through a valid/ready port; channels step only when the output slot is free.
module lfsr_bank #(
    parameter int                NUM_CH = 4,
    parameter int                WIDTH  = 49,
    parameter logic [WIDTH-1:0]  TAPS   = 49'h1_0080_0000_0000,
    parameter int                CNT_W  = 32
) (
    input  logic                      i_clk,
    input  logic                      i_rst_n,
    input  logic                      i_mode,
    input  logic                      i_start,
    input  logic                      i_en,
    input  logic                      i_vld,
    output logic                      o_rdy,
    input  logic [NUM_CH*WIDTH-1:0]   i_data,
    input  logic                      i_cfg_ld,
    input  logic [WIDTH-1:0]          i_taps,
    input  logic [CNT_W-1:0]          i_stop_cnt,
    input  logic                      i_rdy,
    output logic                      o_vld,
    output logic [NUM_CH*WIDTH-1:0]   o_data,
    output logic                      o_done,
    output logic [NUM_CH-1:0]         o_lockup,
    output logic [CNT_W-1:0]          o_cnt,
    output logic [1:0]                o_state
);

    // Handshake: a beat transfers on a cycle where o_vld && i_rdy; o_vld and o_data
    // hold until then. The input side accepts on i_vld && o_rdy (IDLE, slot free).

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t                    state;
    state_t                    state_nxt;
    logic [WIDTH-1:0]          taps;
    logic                      slot_free;
    logic                      pass_ld;
    logic                      step;
    logic                      run_start;
    logic                      taps_wr;
    logic                      done_set;
    logic [NUM_CH*WIDTH-1:0]   step_data;
    logic [NUM_CH-1:0]         lock_mask;

    assign slot_free = !o_vld || i_rdy;
    assign o_rdy     = slot_free && (state == IDLE);
    assign o_state   = state;

    // An all-ones channel is the XNOR lock-up state; it reloads zero instead of shifting.
    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        logic [WIDTH-1:0] cur;
        assign cur                           = o_data[c*WIDTH +: WIDTH];
        assign lock_mask[c]                  = &cur;
        assign step_data[c*WIDTH +: WIDTH]   = lock_mask[c] ? '0 : {cur[WIDTH-2:0], ~^(cur & taps)};
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        pass_ld   = 1'b0;
        step      = 1'b0;
        run_start = 1'b0;
        taps_wr   = 1'b0;
        done_set  = 1'b0;
        case (state)
            IDLE: begin
                pass_ld = !i_mode && i_vld && slot_free;
                taps_wr = i_cfg_ld && (i_taps != '0);
                if (i_mode && i_start) begin
                    run_start = 1'b1;
                    done_set  = (i_stop_cnt == '0);
                    state_nxt = (i_stop_cnt == '0) ? DONE : RUN;
                end
            end
            RUN: begin
                if (!i_mode) begin
                    state_nxt = IDLE;
                end else if (i_en && slot_free) begin
                    step = 1'b1;
                    if ((o_cnt + CNT_W'(1)) == i_stop_cnt) begin
                        done_set  = 1'b1;
                        state_nxt = DONE;
                    end
                end
            end
            DONE: begin
                if (!i_mode) begin
                    state_nxt = IDLE;
                end else if (i_start) begin
                    run_start = 1'b1;
                    done_set  = (i_stop_cnt == '0);
                    state_nxt = (i_stop_cnt == '0) ? DONE : RUN;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_data   <= '0;
            taps     <= TAPS;
            o_vld    <= 1'b0;
            o_done   <= 1'b0;
            o_lockup <= '0;
            o_cnt    <= '0;
        end else begin
            o_lockup <= step ? lock_mask : '0;
            if (pass_ld) begin
                o_data <= i_data;
            end else if (step) begin
                o_data <= step_data;
            end
            if (taps_wr) begin
                taps <= i_taps;
            end
            if (pass_ld || step) begin
                o_vld <= 1'b1;
            end else if (i_rdy) begin
                o_vld <= 1'b0;
            end
            if (run_start) begin
                o_cnt <= '0;
            end else if (step) begin
                o_cnt <= o_cnt + CNT_W'(1);
            end
            if (done_set) begin
                o_done <= 1'b1;
            end else if (run_start) begin
                o_done <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_lfsr_bank.sv
// Bench for lfsr_bank (2 channels x 4 bits): a per-channel LFSR model predicts every
// beat into an expected queue that is compared whenever o_vld is high.
module tb_lfsr_bank;

    localparam int NUM_CH = 2;
    localparam int WIDTH  = 4;
    localparam int CNT_W  = 16;
    localparam int DW     = NUM_CH * WIDTH;

    logic              clk;
    logic              rst_n;
    logic              i_mode;
    logic              i_start;
    logic              i_en;
    logic              i_vld;
    logic              o_rdy;
    logic [DW-1:0]     i_data;
    logic              i_cfg_ld;
    logic [WIDTH-1:0]  i_taps;
    logic [CNT_W-1:0]  i_stop_cnt;
    logic              i_rdy;
    logic              o_vld;
    logic [DW-1:0]     o_data;
    logic              o_done;
    logic [NUM_CH-1:0] o_lockup;
    logic [CNT_W-1:0]  o_cnt;
    logic [1:0]        o_state;

    lfsr_bank #(
        .NUM_CH (NUM_CH),
        .WIDTH  (WIDTH),
        .TAPS   (4'hC),
        .CNT_W  (CNT_W)
    ) dut (
        .i_clk      (clk),
        .i_rst_n    (rst_n),
        .i_mode     (i_mode),
        .i_start    (i_start),
        .i_en       (i_en),
        .i_vld      (i_vld),
        .o_rdy      (o_rdy),
        .i_data     (i_data),
        .i_cfg_ld   (i_cfg_ld),
        .i_taps     (i_taps),
        .i_stop_cnt (i_stop_cnt),
        .i_rdy      (i_rdy),
        .o_vld      (o_vld),
        .o_data     (o_data),
        .o_done     (o_done),
        .o_lockup   (o_lockup),
        .o_cnt      (o_cnt),
        .o_state    (o_state)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int              n_tests = 0;
    int              n_fail  = 0;
    logic [DW-1:0]   exp_q[$];
    logic [WIDTH-1:0] m_st[NUM_CH];
    logic [WIDTH-1:0] m_taps;
    bit              in_run = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference: next value is the shifted state with feedback 1 when the number of
    // tapped ones is even; an all-ones channel recovers to zero.
    function automatic logic [WIDTH-1:0] lfsr_next(input logic [WIDTH-1:0] s, input logic [WIDTH-1:0] t);
        int ones;
        int v;
        logic [31:0] r;
        if (s == {WIDTH{1'b1}}) return '0;
        ones = $countones(s & t);
        v = (int'(s) * 2) % (1 << WIDTH) + ((ones % 2 == 0) ? 1 : 0);
        r = v;
        return r[WIDTH-1:0];
    endfunction

    task automatic model_step(output logic [NUM_CH-1:0] lk);
        logic [DW-1:0] beat;
        lk = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            lk[c] = (m_st[c] == {WIDTH{1'b1}});
            m_st[c] = lfsr_next(m_st[c], m_taps);
            beat[c*WIDTH +: WIDTH] = m_st[c];
        end
        exp_q.push_back(beat);
    endtask

    // scoreboard sampled on the falling edge, inputs change 1 time unit after the rising edge
    task automatic step_clk();
        @(negedge clk);
        if (o_vld) begin
            if (exp_q.size() == 0) begin
                check("beat_unexpected", 32'(o_vld), 32'd0);
            end else begin
                check("beat_data", 32'(o_data), 32'(exp_q[0]));
            end
        end
        if (in_run) begin
            check("done_timing", 32'(o_done), 32'(((exp_q.size() == 1) && o_vld) || (exp_q.size() == 0)));
        end
        if (o_vld && i_rdy && exp_q.size() != 0) void'(exp_q.pop_front());
        @(posedge clk);
        #1;
    endtask

    task automatic pass_seed(input logic [DW-1:0] d);
        i_mode = 1'b0;
        i_vld  = 1'b0;
        i_rdy  = 1'b1;
        step_clk();
        i_vld  = 1'b1;
        i_data = d;
        exp_q.push_back(d);
        for (int c = 0; c < NUM_CH; c++) m_st[c] = d[c*WIDTH +: WIDTH];
        step_clk();
        i_vld = 1'b0;
        step_clk();
    endtask

    task automatic run(input int n, input bit rnd, input bit ld, input logic [WIDTH-1:0] t);
        int budget;
        logic [NUM_CH-1:0] lk;
        if (ld && t != '0) m_taps = t;
        for (int k = 0; k < n; k++) model_step(lk);
        i_mode     = 1'b1;
        i_start    = 1'b1;
        i_stop_cnt = CNT_W'(n);
        i_cfg_ld   = ld;
        i_taps     = t;
        i_en       = 1'b1;
        i_rdy      = 1'b1;
        step_clk();
        i_start  = 1'b0;
        i_cfg_ld = 1'b0;
        in_run   = 1;
        budget   = 0;
        while ((exp_q.size() != 0 || o_vld) && budget < 500) begin
            if (rnd) begin
                i_rdy = 1'($urandom_range(0, 1));
                i_en  = 1'($urandom_range(0, 1));
            end
            step_clk();
            budget++;
        end
        in_run = 0;
        i_rdy  = 1'b1;
        i_en   = 1'b1;
        check("run_timeout", 32'(budget < 500), 32'd1);
        check("run_cnt", 32'(o_cnt), 32'(n));
        check("run_done", 32'(o_done), 32'd1);
        check("run_state", 32'(o_state), 32'd2);
    endtask

    initial begin
        logic [NUM_CH-1:0] lk;
        rst_n = 1'b0; i_mode = 1'b0; i_start = 1'b0; i_en = 1'b0; i_vld = 1'b0;
        i_data = '0; i_cfg_ld = 1'b0; i_taps = '0; i_stop_cnt = '0; i_rdy = 1'b0;
        for (int c = 0; c < NUM_CH; c++) m_st[c] = '0;
        m_taps = 4'hC;
        #12;
        check("rst_vld", 32'(o_vld), 32'd0);
        check("rst_data", 32'(o_data), 32'd0);
        check("rst_done", 32'(o_done), 32'd0);
        check("rst_cnt", 32'(o_cnt), 32'd0);
        check("rst_lockup", 32'(o_lockup), 32'd0);
        check("rst_rdy", 32'(o_rdy), 32'd1);
        @(posedge clk); #1;
        rst_n = 1'b1;
        step_clk();

        // full 15-step run with default taps from the zero state
        run(15, 0, 0, '0);
        check("seq_last", 32'(o_data), 32'h00);

        // pass mode with backpressure
        i_mode = 1'b0;
        step_clk();
        i_rdy  = 1'b0;
        i_vld  = 1'b1;
        i_data = 8'h5A;
        exp_q.push_back(8'h5A);
        step_clk();
        i_vld = 1'b0;
        check("pass_vld", 32'(o_vld), 32'd1);
        check("pass_rdy_bp", 32'(o_rdy), 32'd0);
        for (int k = 0; k < 3; k++) step_clk();
        check("pass_hold", 32'(o_data), 32'h5A);
        check("done_sticky", 32'(o_done), 32'd1);
        i_rdy = 1'b1;
        step_clk();
        check("pass_accept", 32'(o_vld), 32'd0);
        check("pass_rdy", 32'(o_rdy), 32'd1);
        m_st[0] = 4'hA; m_st[1] = 4'h5;

        // lock-up recovery on channel 1 only
        pass_seed({4'hF, 4'h5});
        model_step(lk);
        model_step(lk);
        i_mode = 1'b1; i_start = 1'b1; i_stop_cnt = 16'd2; i_en = 1'b1; i_rdy = 1'b1;
        step_clk();
        i_start = 1'b0;
        check("lock_pre", 32'(o_lockup), 32'd0);
        check("run_rdy", 32'(o_rdy), 32'd0);
        step_clk();
        check("lock_pulse", 32'(o_lockup), 32'h2);
        step_clk();
        check("lock_clear", 32'(o_lockup), 32'd0);
        step_clk();

        // new taps loaded together with start
        pass_seed(8'h00);
        run(4, 0, 1, 4'h9);
        check("cfg_taps9", 32'(o_data), 32'hAA);
        i_mode = 1'b0;
        step_clk();
        i_cfg_ld = 1'b1; i_taps = 4'h0;
        step_clk();
        i_cfg_ld = 1'b0;
        pass_seed(8'h00);
        run(2, 0, 0, '0);
        check("cfg_zero_ignored", 32'(o_data), 32'h22);

        // randomized runs: random seeds, lengths, taps and backpressure
        for (int it = 0; it < 8; it++) begin
            pass_seed(DW'($urandom_range(0, 255)));
            run($urandom_range(1, 12), 1, 1'($urandom_range(0, 1)), WIDTH'($urandom_range(0, 15)));
        end

        // abort after three steps
        i_mode = 1'b0;
        step_clk();
        model_step(lk); model_step(lk); model_step(lk);
        i_mode = 1'b1; i_start = 1'b1; i_stop_cnt = 16'd10; i_en = 1'b1; i_rdy = 1'b1;
        step_clk();
        i_start = 1'b0;
        for (int k = 0; k < 3; k++) step_clk();
        check("abort_cnt_pre", 32'(o_cnt), 32'd3);
        i_mode = 1'b0;
        step_clk();
        check("abort_state", 32'(o_state), 32'd0);
        check("abort_done", 32'(o_done), 32'd0);
        check("abort_cnt", 32'(o_cnt), 32'd3);
        check("abort_vld", 32'(o_vld), 32'd0);
        check("abort_q", 32'(exp_q.size()), 32'd0);

        // zero stop count finishes immediately without a beat
        i_mode = 1'b1; i_start = 1'b1; i_stop_cnt = 16'd0;
        step_clk();
        i_start = 1'b0;
        check("stop0_done", 32'(o_done), 32'd1);
        check("stop0_vld", 32'(o_vld), 32'd0);
        check("stop0_state", 32'(o_state), 32'd2);
        step_clk();
        check("stop0_novld", 32'(o_vld), 32'd0);

        // asynchronous reset in the middle of a run
        model_step(lk); model_step(lk);
        i_start = 1'b1; i_stop_cnt = 16'd10;
        step_clk();
        i_start = 1'b0;
        step_clk();
        step_clk();
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_vld", 32'(o_vld), 32'd0);
        check("arst_data", 32'(o_data), 32'd0);
        check("arst_cnt", 32'(o_cnt), 32'd0);
        check("arst_done", 32'(o_done), 32'd0);
        check("arst_state", 32'(o_state), 32'd0);
        exp_q.delete();
        for (int c = 0; c < NUM_CH; c++) m_st[c] = '0;
        m_taps = 4'hC;
        i_mode = 1'b0;
        step_clk();
        rst_n = 1'b1;
        step_clk();
        run(3, 0, 0, '0);
        check("post_rst_taps", 32'(o_data), 32'h77);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/lfsr_bank.md
Name: lfsr_bank

Overview:
- Multi-channel, parametrised LFSR stimulus engine. NUM_CH independent WIDTH-bit XNOR-form LFSRs share one runtime-programmable tap mask and one control FSM.
- Provides two modes: a pass/seed-load mode, and a random mode that runs for a programmable number of steps.
- Output uses a valid/ready handshake with backpressure. Includes lock-up recovery and a sticky done flag.
- Sits between the test-vector source and the systolic array input skew buffers.

Parameters:
- NUM_CH, 4, number of LFSR channels.
- WIDTH, 49, bits per channel.
- TAPS, 49'h1_0080_0000_0000, reset tap mask. Bit i set means stage i+1 is tapped (default taps 49,40).
- CNT_W, 32, step counter / stop count width.

Ports:
- i_clk  in  1  clock.
- i_rst_n  in  1  asynchronous active-low reset.
- i_mode  in  1  0 = pass/seed load, 1 = random.
- i_start  in  1  pulse; begins a random run.
- i_en  in  1  step enable in random mode.
- i_vld  in  1  input data valid (pass mode).
- o_rdy  out  1  input accept; equals (!o_vld | i_rdy) & (state==IDLE).
- i_data  in  NUM_CH*WIDTH  seeds/pass data; channel c occupies [c*WIDTH +: WIDTH].
- i_cfg_ld  in  1  load i_taps into the tap register.
- i_taps  in  WIDTH  tap mask.
- i_stop_cnt  in  CNT_W  number of random steps per run.
- i_rdy  in  1  downstream ready.
- o_vld  out  1  output valid.
- o_data  out  NUM_CH*WIDTH  channel states.
- o_done  out  1  sticky; run completed.
- o_lockup  out  NUM_CH  one-cycle pulse per channel on lock-up recovery.
- o_cnt  out  CNT_W  steps taken in the current run.

Behaviour:
- Reset (async, i_rst_n=0):
  - All channel states 0.
  - Tap register = TAPS.
  - o_vld, o_done, o_lockup, o_cnt = 0.
  - FSM = IDLE.
- Feedback per channel: fb = ~^(state & taps). Step: state <= {state[WIDTH-2:0], fb}.
- Lock-up: at a step, a channel whose state is all-ones reloads 0 instead of shifting, and its o_lockup bit pulses high for that cycle+1 (registered).
- Output slot: "free" = !o_vld | i_rdy.
  - o_vld, once set, holds along with o_data until i_rdy.
  - o_vld clears on i_rdy when no new beat is produced that cycle.
- FSM IDLE:
  - i_mode=0 and i_vld and slot free: state <= i_data; o_vld=1 next cycle (latency 1; o_data = i_data).
  - i_cfg_ld: tap reg <= i_taps. A zero mask is ignored and the previous mask is kept.
  - i_mode=1 and i_start: o_cnt<=0, o_done<=0.
    - If i_stop_cnt==0, go to DONE directly (o_done=1, no beat).
    - Otherwise go to RUN.
  - i_cfg_ld and i_start in the same cycle: both take effect; the first step uses the new taps.
- FSM RUN:
  - Step when i_en and slot free: all channels advance, o_vld=1 next cycle, o_cnt++.
  - If o_cnt+1 == i_stop_cnt on a step, go to DONE and set o_done.
  - i_en=0 or slot full: states hold (no step, no count).
  - i_mode falls to 0: abort to IDLE, o_done stays 0, o_cnt holds, and any pending beat is still held until accepted.
  - i_start, i_vld and i_cfg_ld are ignored.
- FSM DONE:
  - No steps. The last beat is held until accepted.
  - i_start (i_mode=1) restarts the run from the current states (no reseed) and clears o_done/o_cnt.
  - i_mode=0: go to IDLE. o_done stays set until the next i_start.
- i_stop_cnt is sampled continuously and must be held stable during RUN.
- Reset mid-run: immediate return to reset values; the pending beat is lost.

Test Plan:
- Config NUM_CH=2, WIDTH=4, TAPS=4'hC, reset, i_mode=1, i_start, i_stop_cnt=15, i_en=1, i_rdy=1 -> each channel emits 1,3,7,E,D,B,6,C,9,2,5,A,4,8,0 on 15 consecutive o_vld beats. o_done rises with beat 15; o_cnt=15.
- Pass mode, i_vld with i_data={4'h5,4'hA} -> next cycle o_vld=1, o_data=8'h5A. Hold i_rdy=0: o_data stable and o_rdy=0. Then set i_rdy=1.
- Random run with i_rdy toggled 1,0,0,1 -> no steps while a beat is unaccepted, no values skipped or repeated, o_cnt counts only accepted-slot steps.
- Seed channel 1 with 4'hF, step once -> channel 1 becomes 0, o_lockup=2'b10 for one cycle, channel 0 unaffected.
- i_cfg_ld with i_taps=4'h9 plus i_start together, seed 0 -> first beat uses the new taps. Also i_taps=0 -> tap reg unchanged.
- i_stop_cnt=0 with i_start -> DONE in one cycle, o_done=1, no o_vld. Separately, drop i_mode mid-run at o_cnt=3 -> IDLE, o_done=0, o_cnt=3. Assert i_rst_n low mid-run -> all outputs 0 asynchronously.
